// File: rtl/ccm_arbiter.sv
// Round-robin arbiter sharing the ccm_controller port between fetch (m0) and load/store (m1).
// Read responses are steered back to their issuer through an in-order tag FIFO.
module ccm_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  cntlr_rd,
  output logic [ADDR_WIDTH-1:0] cntlr_raddr,
  output logic                  cntlr_wr,
  output logic [ADDR_WIDTH-1:0] cntlr_waddr,
  output logic [DATA_WIDTH-1:0] cntlr_wr_data,
  input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
  input  logic                  cntlr_rd_valid,
  output logic                  proto_err
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

  logic [MAX_OUTST-1:0]  tag_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  rr_pri;

  logic                  m0_elig;
  logic                  m1_elig;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  push;
  logic                  pop;
  logic                  head_id;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on the pre-edge count, so a pop this cycle does not unblock a read
  always_comb begin
    m0_elig   = m0_req & (m0_we | (fifo_count < MAX_CNT));
    m1_elig   = m1_req & (m1_we | (fifo_count < MAX_CNT));
    m0_gnt    = m0_elig & (~m1_elig | ~rr_pri);
    m1_gnt    = m1_elig & (~m0_elig | rr_pri);
    any_gnt   = m0_gnt | m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    push      = any_gnt & ~sel_we;
    pop       = cntlr_rd_valid & (fifo_count != '0);
    head_id   = tag_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri        <= 1'b0;
      cntlr_rd      <= 1'b0;
      cntlr_wr      <= 1'b0;
      cntlr_raddr   <= '0;
      cntlr_waddr   <= '0;
      cntlr_wr_data <= '0;
    end else begin
      if (any_gnt) rr_pri <= ~m1_gnt;
      cntlr_rd <= any_gnt & ~sel_we;
      cntlr_wr <= any_gnt & sel_we;
      if (any_gnt & ~sel_we) cntlr_raddr <= sel_addr;
      if (any_gnt & sel_we) begin
        cntlr_waddr   <= sel_addr;
        cntlr_wr_data <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= m1_gnt;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A response with nothing outstanding is dropped and latched as a protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      proto_err <= 1'b0;
    end else begin
      m0_rvalid <= pop & ~head_id;
      m1_rvalid <= pop & head_id;
      if (pop & ~head_id) m0_rdata <= cntlr_rd_data;
      if (pop & head_id)  m1_rdata <= cntlr_rd_data;
      if (cntlr_rd_valid & (fifo_count == '0)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccm_arbiter.sv
// Directed bench for ccm_arbiter with a one-cycle-latency controller model.
// The instance uses four outstanding reads so continuous contention never stalls.
module tb_ccm_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int OUTS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          cntlr_rd, cntlr_wr, cntlr_rd_valid, proto_err;
  logic [AW-1:0] cntlr_raddr, cntlr_waddr;
  logic [DW-1:0] cntlr_wr_data, cntlr_rd_data;

  logic          ctl_auto;
  logic          man_valid;
  logic [DW-1:0] man_data;
  logic          model_valid = 1'b0;
  logic [DW-1:0] model_data  = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ccm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
    .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid),
    .proto_err(proto_err)
  );

  // Controller stand-in: writes land in mem, reads answer one cycle after the strobe
  always @(posedge clk) begin
    if (cntlr_wr) mem[cntlr_waddr] <= cntlr_wr_data;
    model_valid <= cntlr_rd;
    model_data  <= mem[cntlr_raddr];
  end

  assign cntlr_rd_valid = ctl_auto ? model_valid : man_valid;
  assign cntlr_rd_data  = ctl_auto ? model_data  : man_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cntlr_rd, cntlr_wr, m0_rvalid, m1_rvalid, proto_err} !== 5'b0)
      $display("[TB] FAIL reset_strobes: got %b expected 00000", {cntlr_rd, cntlr_wr, m0_rvalid, m1_rvalid, proto_err});
    else passed++;
    total++;
    if ({cntlr_raddr, cntlr_waddr, cntlr_wr_data, m0_rdata, m1_rdata} !== '0)
      $display("[TB] FAIL reset_buses: got %h expected 0", {cntlr_raddr, cntlr_waddr, cntlr_wr_data, m0_rdata, m1_rdata});
    else passed++;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b00)
      $display("[TB] FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'd10; m0_wdata = 32'hDEADBEEF;
    #3;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("[TB] FAIL write_gnt: got %b expected 10", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m0_req = 1'b0;
    total++;
    if ({cntlr_wr, cntlr_rd} !== 2'b10 || cntlr_waddr !== 11'd10 || cntlr_wr_data !== 32'hDEADBEEF)
      $display("[TB] FAIL write_issue: got wr=%b rd=%b addr=%0d data=%h expected wr=1 rd=0 addr=10 data=deadbeef",
               cntlr_wr, cntlr_rd, cntlr_waddr, cntlr_wr_data);
    else passed++;
    step();
    total++;
    if (cntlr_wr !== 1'b0 || cntlr_wr_data !== 32'hDEADBEEF || {m0_rvalid, m1_rvalid} !== 2'b00)
      $display("[TB] FAIL write_one_shot: got wr=%b data=%h rv=%b expected wr=0 data=deadbeef rv=00",
               cntlr_wr, cntlr_wr_data, {m0_rvalid, m1_rvalid});
    else passed++;
  endtask

  task automatic test_read_back();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd10;
    #3;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("[TB] FAIL rb_gnt: got %b expected 01", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m1_req = 1'b0;
    total++;
    if (cntlr_rd !== 1'b1 || cntlr_raddr !== 11'd10)
      $display("[TB] FAIL rb_issue: got rd=%b addr=%0d expected rd=1 addr=10", cntlr_rd, cntlr_raddr);
    else passed++;
    step();
    total++;
    if (cntlr_rd !== 1'b0 || {m0_rvalid, m1_rvalid} !== 2'b00)
      $display("[TB] FAIL rb_early: got rd=%b rv=%b expected rd=0 rv=00", cntlr_rd, {m0_rvalid, m1_rvalid});
    else passed++;
    step();
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL rb_resp: got rv=%b data=%h expected rv=01 data=deadbeef", {m0_rvalid, m1_rvalid}, m1_rdata);
    else passed++;
    step();
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m1_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL rb_pulse: got rv=%b data=%h expected rv=00 data=deadbeef", {m0_rvalid, m1_rvalid}, m1_rdata);
    else passed++;
  endtask

  task automatic test_contention();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd2;
    for (int i = 0; i < 4; i++) begin
      #3;
      total++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("[TB] FAIL contend_gnt%0d: got %b expected %b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else passed++;
      step();
      total++;
      if (cntlr_rd !== 1'b1 || cntlr_raddr !== ((i % 2 == 0) ? 11'd1 : 11'd2))
        $display("[TB] FAIL contend_addr%0d: got rd=%b addr=%0d expected rd=1 addr=%0d", i, cntlr_rd, cntlr_raddr,
                 (i % 2 == 0) ? 1 : 2);
      else passed++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (5) step();
    total++;
    if (proto_err !== 1'b0)
      $display("[TB] FAIL contend_err: got %b expected 0", proto_err);
    else passed++;
  endtask

  task automatic test_outstanding_limit();
    ctl_auto = 1'b0; man_valid = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd5;
    for (int i = 0; i < OUTS; i++) begin
      #3;
      total++;
      if (m0_gnt !== 1'b1)
        $display("[TB] FAIL limit_gnt%0d: got %b expected 1", i, m0_gnt);
      else passed++;
      step();
    end
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd20; m1_wdata = 32'hA5A5A5A5;
    #3;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("[TB] FAIL limit_full: got %b expected 01", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m1_req = 1'b0;
    man_valid = 1'b1; man_data = 32'h0BADF00D;
    total++;
    if (cntlr_wr !== 1'b1 || cntlr_waddr !== 11'd20)
      $display("[TB] FAIL limit_write: got wr=%b addr=%0d expected wr=1 addr=20", cntlr_wr, cntlr_waddr);
    else passed++;
    #3;
    total++;
    if (m0_gnt !== 1'b0)
      $display("[TB] FAIL limit_same_pop: got %b expected 0", m0_gnt);
    else passed++;
    step();
    man_valid = 1'b0;
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h0BADF00D)
      $display("[TB] FAIL limit_resp: got rv=%b data=%h expected rv=10 data=0badf00d", {m0_rvalid, m1_rvalid}, m0_rdata);
    else passed++;
    #3;
    total++;
    if (m0_gnt !== 1'b1)
      $display("[TB] FAIL limit_unblock: got %b expected 1", m0_gnt);
    else passed++;
    step();
    m0_req = 1'b0;
    for (int i = 0; i < OUTS; i++) begin
      man_valid = 1'b1; man_data = 32'd100 + 32'(i);
      step();
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'd100 + 32'(i))
        $display("[TB] FAIL limit_drain%0d: got rv=%b data=%0d expected rv=1 data=%0d", i, m0_rvalid, m0_rdata, 100 + i);
      else passed++;
    end
    man_valid = 1'b0;
    step();
    total++;
    if (m0_rvalid !== 1'b0 || proto_err !== 1'b0)
      $display("[TB] FAIL limit_empty: got rv=%b err=%b expected rv=0 err=0", m0_rvalid, proto_err);
    else passed++;
  endtask

  task automatic test_routing_order();
    ctl_auto = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'd3; m0_wdata = 32'h11111111;
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'd4; m1_wdata = 32'h22222222;
    step();
    m1_req = 1'b0;
    repeat (2) step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd3;
    #3;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("[TB] FAIL order_gnt0: got %b expected 10", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd4;
    #3;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("[TB] FAIL order_gnt1: got %b expected 01", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m1_req = 1'b0;
    step();
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h11111111)
      $display("[TB] FAIL order_first: got rv=%b data=%h expected rv=10 data=11111111", {m0_rvalid, m1_rvalid}, m0_rdata);
    else passed++;
    step();
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h22222222)
      $display("[TB] FAIL order_second: got rv=%b data=%h expected rv=01 data=22222222", {m0_rvalid, m1_rvalid}, m1_rdata);
    else passed++;
    step();
  endtask

  task automatic test_error_reset();
    ctl_auto = 1'b0;
    man_valid = 1'b1; man_data = 32'hCAFECAFE;
    step();
    man_valid = 1'b0;
    total++;
    if (proto_err !== 1'b1 || {m0_rvalid, m1_rvalid} !== 2'b00)
      $display("[TB] FAIL err_set: got err=%b rv=%b expected err=1 rv=00", proto_err, {m0_rvalid, m1_rvalid});
    else passed++;
    repeat (3) step();
    total++;
    if (proto_err !== 1'b1)
      $display("[TB] FAIL err_sticky: got %b expected 1", proto_err);
    else passed++;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 11'd7; m0_wdata = 32'h12345678;
    step();
    m0_req = 1'b0;
    total++;
    if (cntlr_wr !== 1'b1)
      $display("[TB] FAIL err_midwrite: got %b expected 1", cntlr_wr);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cntlr_wr, cntlr_rd, proto_err} !== 3'b000 || cntlr_waddr !== '0)
      $display("[TB] FAIL async_reset: got wr=%b rd=%b err=%b addr=%0d expected all 0",
               cntlr_wr, cntlr_rd, proto_err, cntlr_waddr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'd2;
    #1;
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("[TB] FAIL reset_pri: got %b expected 10", {m0_gnt, m1_gnt});
    else passed++;
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    man_valid = 1'b1; man_data = 32'h5A5A0001;
    step();
    man_valid = 1'b0;
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h5A5A0001 || proto_err !== 1'b0)
      $display("[TB] FAIL post_reset_resp: got rv=%b data=%h err=%b expected rv=10 data=5a5a0001 err=0",
               {m0_rvalid, m1_rvalid}, m0_rdata, proto_err);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; ctl_auto = 1'b1; man_valid = 1'b0; man_data = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_outstanding_limit();
    test_routing_order();
    test_error_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ccm_arbiter.md
Name: ccm_arbiter

Overview:
- Two-port round-robin arbiter that shares the single read/write port of ccm_controller between two requesters: m0 (instruction fetch) and m1 (load/store).
- Issues at most one registered command per cycle to the controller.
- Tracks outstanding reads in an in-order tag FIFO and routes each cntlr_rd_valid/cntlr_rd_data response back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 11, CCM word address width (2048 x 32-bit words).
- DATA_WIDTH, 32, data width.
- MAX_OUTST, 2, maximum outstanding reads; tag FIFO depth (power of two, >= 1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 request valid; held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  m0 word address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  combinational; request accepted this cycle.
- m0_rvalid  out  1  registered; one-cycle read response pulse.
- m0_rdata  out  DATA_WIDTH  registered read data, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the m0 ports, for m1.
- cntlr_rd  out  1  registered read strobe to ccm_controller.
- cntlr_raddr  out  ADDR_WIDTH  registered read address.
- cntlr_wr  out  1  registered write strobe.
- cntlr_waddr  out  ADDR_WIDTH  registered write address.
- cntlr_wr_data  out  DATA_WIDTH  registered write data.
- cntlr_rd_data  in  DATA_WIDTH  read data from controller.
- cntlr_rd_valid  in  1  read data valid from controller.
- proto_err  out  1  sticky; response arrived with no read outstanding.

Behaviour:
- Reset (async assert, sync release): all registered outputs = 0; tag FIFO empty (count = 0); rr_pri = 0 (m0 favoured); proto_err = 0.
- Eligibility: mX is eligible when mX_req = 1 AND (mX_we = 1 OR fifo_count < MAX_OUTST).
  - Full is judged on the pre-edge count; a same-cycle pop does not unblock a read.
- Arbitration (combinational, at most one gnt per cycle):
  - Only one eligible requester: grant it.
  - Both eligible: grant mX where X = rr_pri.
  - None eligible: no grant.
  - On any grant to mX, rr_pri <= ~X at the next edge; otherwise rr_pri holds.
- Issue: on the edge after a grant, the command registers load the granted request.
  - Read: cntlr_rd = 1 and cntlr_raddr = addr for exactly one cycle.
  - Write: cntlr_wr = 1 and cntlr_waddr/cntlr_wr_data = addr/wdata for exactly one cycle.
  - Strobes return to 0 the following cycle unless a new grant occurred; back-to-back grants give back-to-back strobes.
  - Address/data registers hold their last value when idle.
- Latency: request to controller strobe = 1 cycle. Response to mX_rvalid = 1 cycle after cntlr_rd_valid.
- Tag FIFO:
  - Push the granted requester ID (1 bit) on a read grant, at the same edge the command registers load.
  - Pop on cntlr_rd_valid = 1.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Read/write pointers wrap modulo MAX_OUTST.
- Response routing:
  - On cntlr_rd_valid with FIFO non-empty, at the next edge m<head>_rvalid = 1 and m<head>_rdata = cntlr_rd_data.
  - The other requester's rvalid stays 0.
  - rdata holds its last value when rvalid = 0.
- Error:
  - cntlr_rd_valid with an empty FIFO: response dropped, no rvalid, proto_err <= 1.
  - proto_err clears only on reset.
  - A reset mid-operation empties the FIFO, so a stale in-flight response after reset sets proto_err.
- Ordering: responses are routed strictly in issue order; the controller returns reads in order. Writes produce no response and never touch the FIFO.
- mX_req dropped before grant: the request is withdrawn, nothing is issued, rr_pri is unaffected.

Test Plan:
- Single write: m0 req/we = 1, addr = 10, wdata = 0xDEADBEEF -> m0_gnt = 1 the same cycle; next cycle cntlr_wr = 1, cntlr_waddr = 10, cntlr_wr_data = 0xDEADBEEF for one cycle; no rvalid.
- Read-back through ccm_controller + sram_8kb: m1 reads addr 10 after the write -> cntlr_rd pulses with raddr = 10; one cycle after cntlr_rd_valid, m1_rvalid = 1 with m1_rdata = 0xDEADBEEF; m0_rvalid stays 0.
- Contention: m0 and m1 both read (addr 1, addr 2) continuously for 4 cycles with MAX_OUTST large -> grant sequence m0, m1, m0, m1; cntlr_raddr sequence 1, 2, 1, 2.
- Outstanding limit: with MAX_OUTST = 2 and controller responses stalled, three reads are requested -> only 2 grants; 3rd gnt = 0 until the cycle after a cntlr_rd_valid; writes from the other port are still granted meanwhile.
- Routing order: m0 reads addr 3 (0x11111111), then m1 reads addr 4 (0x22222222) -> m0_rvalid with 0x11111111 first, then m1_rvalid with 0x22222222.
- Error/reset: force cntlr_rd_valid = 1 with nothing outstanding -> proto_err = 1 and stays 1; assert rst_n = 0 mid-write -> all strobes and proto_err = 0 immediately (asynchronous), rr_pri = m0.
